// File: rtl/pe_traffic_gen.sv
// pe_traffic_gen: synthetic-pattern packet source with gap/back-pressure plus a counting sink.
// Define PE_DEST_CHECK_EN to count received packets whose dest field differs from ADDRESS.
module pe_traffic_gen #(
    parameter int ADDRESS       = 0,
    parameter int NUM_PE        = 8,
    parameter int ADDRESS_WIDTH = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int PKT_LIMIT     = 100,
    parameter int PATTERN       = 0,
    parameter int GAP_CYCLES    = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_start,
    output logic [ADDRESS_WIDTH+DATA_WIDTH-1:0] o_data,
    output logic                                o_data_valid,
    input  logic                                i_data_ready,
    input  logic [ADDRESS_WIDTH+DATA_WIDTH-1:0] i_data,
    input  logic                                i_data_valid,
    output logic                                o_data_ready,
    output logic                                o_done,
    output logic [31:0]                         o_sent_count,
    output logic [31:0]                         o_rcvd_count,
    output logic [31:0]                         o_err_count
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam logic [AW-1:0] MY_ADDR = AW'(ADDRESS);
    localparam logic [15:0] SEED = (16'(ADDRESS + 1) == 16'd0) ? 16'd1 : 16'(ADDRESS + 1);
    localparam logic [DW-1:0] BASE = DW'(PKT_LIMIT * ADDRESS);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_idx, r_gap, r_rcvd;
    logic [15:0]      r_lfsr, w_lfsr_nxt;
    logic [AW+DW-1:0] r_data;
    logic             w_accept, w_last;

    // Only RANDOM depends on the LFSR; every other pattern folds to a constant.
    function automatic logic [AW-1:0] f_dest(input logic [15:0] lfsr);
        logic [AW-1:0] d;
        d = '0;
        for (int j = 0; j < AW; j++)
            d[j] = (PATTERN == 1) ? ~MY_ADDR[j] :
                   (PATTERN == 2) ? MY_ADDR[AW-1-j] :
                   (PATTERN == 3) ? MY_ADDR[(j+1)%AW] :
                   (PATTERN == 4) ? MY_ADDR[(j+AW/2)%AW] : 1'b0;
        return (PATTERN == 0) ? AW'(lfsr % 16'(NUM_PE)) :
               (PATTERN == 5) ? AW'((ADDRESS + (NUM_PE + 1) / 2) % NUM_PE) :
               (PATTERN == 6) ? AW'((ADDRESS + 1) % NUM_PE) : d;
    endfunction

    assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_accept   = (r_state == SEND) && i_data_ready;
    assign w_last     = (r_idx + 32'd1) == 32'(PKT_LIMIT);

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = i_start ? ((PKT_LIMIT == 0) ? DONE : SEND) : IDLE;
            SEND:    w_state_nxt = !w_accept ? SEND : w_last ? DONE : (GAP_CYCLES == 0) ? SEND : GAP;
            GAP:     w_state_nxt = (r_gap == 32'd0) ? SEND : GAP;
            default: w_state_nxt = DONE;
        endcase
    end

    always_comb begin
        o_data_valid = (r_state == SEND);
        o_done       = (r_state == DONE);
    end

    // r_data always holds the packet for the current index so it is ready the cycle SEND is entered.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_idx  <= '0;
            r_gap  <= '0;
            r_lfsr <= SEED;
            r_data <= '0;
            r_rcvd <= '0;
        end else begin
            if (r_state == IDLE && i_start)
                r_data <= {f_dest(r_lfsr), BASE + DW'(r_idx)};
            if (w_accept) begin
                r_idx  <= r_idx + 32'd1;
                r_lfsr <= w_lfsr_nxt;
                r_data <= {f_dest(w_lfsr_nxt), BASE + DW'(r_idx + 32'd1)};
            end
            r_gap  <= w_accept ? 32'(GAP_CYCLES - 1) : (r_state == GAP) ? r_gap - 32'd1 : r_gap;
            r_rcvd <= r_rcvd + 32'(i_data_valid);
        end

`ifdef PE_DEST_CHECK_EN
    logic [31:0] r_err;
    logic        w_unused;
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_err <= '0;
        else      r_err <= r_err + 32'(i_data_valid && (i_data[DW+:AW] != MY_ADDR));
    assign o_err_count = r_err;
    assign w_unused    = ^i_data[DW-1:0];
`else
    logic w_unused;
    assign o_err_count = '0;
    assign w_unused    = ^i_data;
`endif

    assign o_data       = r_data;
    assign o_data_ready = 1'b1;
    assign o_sent_count = r_idx;
    assign o_rcvd_count = r_rcvd;
endmodule
